aes_sts_arb: RTL

Round-robin scheduler that shares the single S2MM status AXI-Stream between up to eight AES channel engines. Each channel raises a request with a 32-bit status word. The arbiter grants one channel at a time and emits a fixed-length status frame on `s_axis_s2mm_sts_*`: the latched word first, zero beats after it, and `tlast` on the final beat. It then pulses an acknowledge to the granted channel. It sits between the per-channel AES status FSMs and the DMA S2MM status port.

---
 rtl/aes_sts_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/aes_sts_arb.sv
// Round-robin arbiter that shares the S2MM status AXI-Stream among the AES channel engines.
// Each grant emits one fixed-length status frame, then pulses an ack to the granted channel.
module aes_sts_arb #(
  parameter int    C_NUM_CH                      = 4,
  parameter int    C_STS_WORDS                   = 5,
  parameter int    C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
  parameter string C_FAMILY                      = "virtex6"
) (
  input  logic                                     m_axi_mm2s_aclk,
  input  logic                                     s2mm_sts_reset_out_n,
  input  logic [C_NUM_CH-1:0]                      ch_sts_req,
  input  logic [C_NUM_CH*32-1:0]                   ch_sts_data,
  output logic [C_NUM_CH-1:0]                      ch_sts_ack,
  output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH-1:0] s_axis_s2mm_sts_tdata,
  output logic [3:0]                               s_axis_s2mm_sts_tkeep,
  output logic                                     s_axis_s2mm_sts_tvalid,
  output logic                                     s_axis_s2mm_sts_tlast,
  input  logic                                     s_axis_s2mm_sts_tready,
  output logic                                     aes_sts_busy,
  output logic [31:0]                              aes_sts_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;

  localparam logic [3:0] LAST_BEAT = 4'(C_STS_WORDS - 1);
  localparam logic [2:0] LAST_CH   = 3'(C_NUM_CH - 1);

  // The family string only matters to the surrounding IP wrapper.
  if (C_FAMILY == "") begin : g_no_family
  end

  logic [2:0]  state_q, state_nxt;
  logic [2:0]  grant_q, grant_nxt;
  logic [2:0]  rr_ptr_q, rr_ptr_nxt;
  logic [3:0]  beat_q, beat_nxt;
  logic [7:0]  frame_q, frame_nxt;
  logic [31:0] word_q, word_nxt;
  logic [2:0]  pick;
  logic        beat_done;

  // First requester at or after ptr, wrapping at C_NUM_CH.
  function automatic logic [2:0] rr_pick(input logic [C_NUM_CH-1:0] req,
                                         input logic [2:0] ptr);
    logic [2:0] sel;
    logic       hit;
    int         idx;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < C_NUM_CH; k++) begin
      idx = (int'(ptr) + k) % C_NUM_CH;
      if (!hit && req[idx]) begin
        sel = 3'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick      = rr_pick(ch_sts_req, rr_ptr_q);
  assign beat_done = s_axis_s2mm_sts_tvalid && s_axis_s2mm_sts_tready;

  always_comb begin
    state_nxt  = state_q;
    grant_nxt  = grant_q;
    rr_ptr_nxt = rr_ptr_q;
    beat_nxt   = beat_q;
    frame_nxt  = frame_q;
    word_nxt   = word_q;
    case (state_q)
      S_IDLE: begin
        if (|ch_sts_req) begin
          grant_nxt = pick;
          word_nxt  = ch_sts_data[int'(pick)*32 +: 32];
          beat_nxt  = '0;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (beat_done) begin
          if (beat_q == LAST_BEAT) begin
            state_nxt  = S_ACK;
            rr_ptr_nxt = (grant_q == LAST_CH) ? 3'd0 : grant_q + 3'd1;
            frame_nxt  = frame_q + 8'd1;
          end else begin
            beat_nxt = beat_q + 4'd1;
          end
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and registered outputs: every output is decoded from next-state values.
  always_ff @(posedge m_axi_mm2s_aclk or negedge s2mm_sts_reset_out_n) begin
    if (!s2mm_sts_reset_out_n) begin
      state_q                <= S_IDLE;
      grant_q                <= '0;
      rr_ptr_q               <= '0;
      beat_q                 <= '0;
      frame_q                <= '0;
      s_axis_s2mm_sts_tvalid <= 1'b0;
      s_axis_s2mm_sts_tlast  <= 1'b0;
      s_axis_s2mm_sts_tdata  <= '0;
      ch_sts_ack             <= '0;
      aes_sts_busy           <= 1'b0;
      aes_sts_dbg            <= '0;
    end else begin
      state_q                <= state_nxt;
      grant_q                <= grant_nxt;
      rr_ptr_q               <= rr_ptr_nxt;
      beat_q                 <= beat_nxt;
      frame_q                <= frame_nxt;
      s_axis_s2mm_sts_tvalid <= (state_nxt == S_SEND);
      s_axis_s2mm_sts_tlast  <= (state_nxt == S_SEND) && (beat_nxt == LAST_BEAT);
      s_axis_s2mm_sts_tdata  <= ((state_nxt == S_SEND) && (beat_nxt == 4'd0)) ? word_nxt : '0;
      ch_sts_ack             <= (state_nxt == S_ACK) ? (C_NUM_CH'(1) << grant_nxt) : '0;
      aes_sts_busy           <= (state_nxt != S_IDLE);
      aes_sts_dbg            <= {8'h00, frame_nxt, 4'h0, beat_nxt, 1'b0, grant_nxt, 1'b0, state_nxt};
    end
  end

  // Latched status word is pure data and needs no reset.
  always_ff @(posedge m_axi_mm2s_aclk) begin
    word_q <= word_nxt;
  end

  assign s_axis_s2mm_sts_tkeep = 4'hf;

endmodule
